// File: rtl/err_meas_pkg.sv
// Shared definitions for the approximate-adder error-characterisation sequencer:
// FSM state encoding, LFSR constants and the Galois LFSR next-state helper.
package err_meas_pkg;

  localparam int unsigned LFSR_W       = 32;
  localparam logic [31:0] LFSR_POLY    = 32'h80200003;
  localparam logic [31:0] LFSR_ONE     = 32'h00000001;
  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned DRAIN_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Right-shifting Galois step for x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_POLY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR used as the operand source.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state resets to 1)
//   load, seed : load seed into the register (caller guarantees seed != 0)
//   step       : advance one position
//   state      : current register value
module lfsr32_galois
  import err_meas_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  // Load wins over step so a restart always begins from the new seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_ONE;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/approx_adder_err_ctrl.sv
// Error-characterisation sequencer for an N-bit approximate adder.
// Issues one LFSR operand pair per RUN cycle, recomputes the exact sum two
// stages later and accumulates error count, carry-error count, summed and
// maximum error distance.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : run control (abort has priority)
//   num_tests, seed       : run length and LFSR seed, captured with start
//   dut_a, dut_b          : registered operands to the adder under test
//   dut_sum, dut_carry    : combinational result from the adder under test
//   busy, done            : RUN/DRAIN and DONE indicators
//   err_count, carry_err_count, sum_ed, max_ed : live accumulators
module approx_adder_err_ctrl
  import err_meas_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned SUM_W = N + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_tests,
  input  logic [31:0]      seed,
  output logic [N-1:0]     dut_a,
  output logic [N-1:0]     dut_b,
  input  logic [N-1:0]     dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] carry_err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed
);

  state_t             state_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   issue_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic [31:0]        lfsr_state;
  logic [31:0]        lfsr_nxt_c;
  logic [31:0]        seed_eff_c;
  logic               start_ok_c;
  logic               lfsr_step_c;

  // Stage-1 pipeline registers.
  logic               s1_valid;
  logic [N-1:0]       s1_sum;
  logic               s1_carry;
  logic [N:0]         s1_exact;

  logic [N:0]         exact_c;
  logic [N-1:0]       ed_c;

  // Start is honoured only when idle or finished, and never alongside abort.
  always_comb begin
    start_ok_c  = 1'b0;
    lfsr_step_c = 1'b0;
    seed_eff_c  = seed;
    if (seed == 32'h0) begin
      seed_eff_c = LFSR_ONE;
    end
    if (!abort && start && ((state_q == IDLE) || (state_q == DONE))) begin
      start_ok_c = 1'b1;
    end
    if (!abort && (state_q == RUN)) begin
      lfsr_step_c = 1'b1;
    end
    lfsr_nxt_c = lfsr_next(lfsr_state);
  end

  lfsr32_galois u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok_c),
    .seed  (seed_eff_c),
    .step  (lfsr_step_c),
    .state (lfsr_state)
  );

  // Exact reference sum for stage 1 and unsigned error distance for stage 2.
  always_comb begin
    exact_c = (N+1)'(dut_a) + (N+1)'(dut_b);
    ed_c    = '0;
    if (s1_sum >= s1_exact[N-1:0]) begin
      ed_c = s1_sum - s1_exact[N-1:0];
    end else begin
      ed_c = s1_exact[N-1:0] - s1_sum;
    end
  end

  // Control FSM, operand issue, pipeline and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      num_q           <= '0;
      issue_cnt       <= '0;
      drain_cnt       <= '0;
      dut_a           <= '0;
      dut_b           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      s1_valid        <= 1'b0;
      s1_sum          <= '0;
      s1_carry        <= 1'b0;
      s1_exact        <= '0;
      err_count       <= '0;
      carry_err_count <= '0;
      sum_ed          <= '0;
      max_ed          <= '0;
    end else begin
      // Stage 1 captures whatever pair is on the bus during RUN.
      s1_valid <= (state_q == RUN) && !abort;
      s1_sum   <= dut_sum;
      s1_carry <= dut_carry;
      s1_exact <= exact_c;

      // Stage 2: abort drops the in-flight pair instead of counting it.
      if (start_ok_c) begin
        err_count       <= '0;
        carry_err_count <= '0;
        sum_ed          <= '0;
        max_ed          <= '0;
      end else if (s1_valid && !abort) begin
        err_count       <= err_count + CNT_W'(ed_c != '0);
        carry_err_count <= carry_err_count + CNT_W'(s1_carry != s1_exact[N]);
        sum_ed          <= sum_ed + SUM_W'(ed_c);
        if (ed_c > max_ed) begin
          max_ed <= ed_c;
        end
      end

      if (abort) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
        dut_a   <= '0;
        dut_b   <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              num_q     <= num_tests;
              issue_cnt <= '0;
              if (num_tests == '0) begin
                state_q <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                // First pair is the seed itself; the count includes it.
                state_q   <= RUN;
                busy      <= 1'b1;
                done      <= 1'b0;
                issue_cnt <= CNT_W'(1);
                dut_a     <= seed_eff_c[N-1:0];
                dut_b     <= seed_eff_c[16+N-1:16];
              end
            end
          end
          RUN: begin
            if (issue_cnt == num_q) begin
              state_q   <= DRAIN;
              drain_cnt <= '0;
              dut_a     <= '0;
              dut_b     <= '0;
            end else begin
              issue_cnt <= issue_cnt + CNT_W'(1);
              dut_a     <= lfsr_nxt_c[N-1:0];
              dut_b     <= lfsr_nxt_c[16+N-1:16];
            end
          end
          DRAIN: begin
            // Two cycles let the last pair clear both pipeline stages.
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
